cmp_stream: RTL and testbench



---
 rtl/cmp_stream.sv | 86 ++++++++
 tb/tb_cmp_stream.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/cmp_stream.sv
// cmp_stream: registered a/b comparator with running max/min and saturating less-than count
module cmp_stream #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sgn,
  output logic             out_valid,
  output logic             ans_u,
  output logic             ans_s,
  output logic             eq,
  output logic [WIDTH-1:0] max_a,
  output logic [WIDTH-1:0] min_a,
  output logic [CNT_W-1:0] lt_cnt,
  output logic             cnt_sat,
  output logic             empty
);
  logic             mode;
  logic             first;
  logic             cur_mode;
  logic             lt_u;
  logic             lt_s;
  logic             lt_m;
  logic             new_max;
  logic             new_min;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_nxt;

  function automatic logic lt(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
    return s ? ($signed({x[WIDTH-1], x}) < $signed({y[WIDTH-1], y})) : ({1'b0, x} < {1'b0, y});
  endfunction

  // a clr alongside a sample makes that sample the first of a new stream
  always_comb begin
    first    = empty | clr;
    cur_mode = first ? sgn : mode;
    lt_u     = lt(a, b, 1'b0);
    lt_s     = lt(a, b, 1'b1);
    lt_m     = cur_mode ? lt_s : lt_u;
    new_max  = first | lt(max_a, a, cur_mode);
    new_min  = first | lt(a, min_a, cur_mode);
    cnt_base = first ? '0 : lt_cnt;
    cnt_nxt  = cnt_base + CNT_W'(lt_m & ~&cnt_base);
  end

  // comparison results and stream statistics, all registered
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      ans_u     <= 1'b0;
      ans_s     <= 1'b0;
      eq        <= 1'b0;
      max_a     <= '0;
      min_a     <= '0;
      lt_cnt    <= '0;
      cnt_sat   <= 1'b0;
      empty     <= 1'b1;
      mode      <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        ans_u   <= lt_u;
        ans_s   <= lt_s;
        eq      <= a == b;
        mode    <= cur_mode;
        max_a   <= new_max ? a : max_a;
        min_a   <= new_min ? a : min_a;
        lt_cnt  <= cnt_nxt;
        cnt_sat <= &cnt_nxt;
        empty   <= 1'b0;
      end else if (clr) begin
        max_a   <= '0;
        min_a   <= '0;
        lt_cnt  <= '0;
        cnt_sat <= 1'b0;
        empty   <= 1'b1;
        mode    <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cmp_stream.sv
// tb_cmp_stream: scoreboard bench for cmp_stream, 8-bit and 2-bit counter instances on shared inputs
module tb_cmp_stream;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       sgn = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       out_valid, ans_u, ans_s, eq, cnt_sat, empty;
  logic [3:0] max_a, min_a;
  logic [7:0] lt_cnt;
  logic       out_valid2, ans_u2, ans_s2, eq2, cnt_sat2, empty2;
  logic [3:0] max_a2, min_a2;
  logic [1:0] lt_cnt2;
  int         checks = 0;
  int         errors = 0;
  logic [2:0] sbq[$];

  cmp_stream #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .a(a), .b(b), .sgn(sgn),
    .out_valid(out_valid), .ans_u(ans_u), .ans_s(ans_s), .eq(eq), .max_a(max_a), .min_a(min_a),
    .lt_cnt(lt_cnt), .cnt_sat(cnt_sat), .empty(empty)
  );

  cmp_stream #(.WIDTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .a(a), .b(b), .sgn(sgn),
    .out_valid(out_valid2), .ans_u(ans_u2), .ans_s(ans_s2), .eq(eq2), .max_a(max_a2), .min_a(min_a2),
    .lt_cnt(lt_cnt2), .cnt_sat(cnt_sat2), .empty(empty2)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] va, input logic [3:0] vb, input logic vs, input logic vc);
    logic signed [3:0] sa;
    logic signed [3:0] sb;
    logic [2:0] exp;
    logic [2:0] got;
    sa = va;
    sb = vb;
    a = va;
    b = vb;
    sgn = vs;
    clr = vc;
    in_valid = 1'b1;
    sbq.push_back({va < vb, sa < sb, va == vb});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL out_valid a=%0h b=%0h: got %b want 1", va, vb, out_valid); end
    checks++;
    if (sbq.size() == 0) begin errors++; $display("FAIL scoreboard_empty a=%0h b=%0h", va, vb); end
    else begin
      exp = sbq.pop_front();
      got = {ans_u, ans_s, eq};
      if (got !== exp) begin errors++; $display("FAIL cmp a=%0h b=%0h {u,s,eq}: got %b want %b", va, vb, got, exp); end
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if ({out_valid, ans_u, ans_s, eq, max_a, min_a, lt_cnt, cnt_sat, empty} !== {4'b0, 4'h0, 4'h0, 8'h0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL reset_state: got %b %b %b %b %h %h %h %b %b want 0 0 0 0 0 0 00 0 1", out_valid, ans_u, ans_s, eq, max_a, min_a, lt_cnt, cnt_sat, empty);
    end
  endtask

  task automatic test_compare();
    drive(4'h4, 4'hF, 1'b0, 1'b0);
    drive(4'h4, 4'h7, 1'b0, 1'b0);
    drive(4'h4, 4'hF, 1'b0, 1'b0);
    drive(4'h9, 4'h9, 1'b0, 1'b0);
    drive(4'hA, 4'h3, 1'b0, 1'b0);
    drive(4'h2, 4'hC, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid: got %b want 0", out_valid); end
    checks++;
    if ({ans_u, ans_s, eq} !== 3'b100) begin errors++; $display("FAIL idle_hold: got %b want 100", {ans_u, ans_s, eq}); end
  endtask

  task automatic test_signed_stats();
    pulse_clr();
    checks++;
    if ({empty, lt_cnt, max_a, min_a} !== {1'b1, 8'h0, 4'h0, 4'h0}) begin errors++; $display("FAIL clr_stats: got %b %h %h %h want 1 00 0 0", empty, lt_cnt, max_a, min_a); end
    drive(4'h4, 4'h0, 1'b1, 1'b0);
    drive(4'hF, 4'h0, 1'b1, 1'b0);
    drive(4'h7, 4'h0, 1'b1, 1'b0);
    checks++;
    if ({max_a, min_a, lt_cnt} !== {4'h7, 4'hF, 8'd1}) begin errors++; $display("FAIL signed_stats: got %h %h %0d want 7 f 1", max_a, min_a, lt_cnt); end
    drive(4'h8, 4'h0, 1'b0, 1'b0);
    checks++;
    if ({max_a, min_a, lt_cnt} !== {4'h7, 4'h8, 8'd2}) begin errors++; $display("FAIL signed_latched: got %h %h %0d want 7 8 2", max_a, min_a, lt_cnt); end
  endtask

  task automatic test_unsigned_stats();
    pulse_clr();
    drive(4'h4, 4'h8, 1'b0, 1'b0);
    drive(4'hF, 4'h8, 1'b0, 1'b0);
    drive(4'h7, 4'h8, 1'b0, 1'b0);
    checks++;
    if ({max_a, min_a, lt_cnt, empty} !== {4'hF, 4'h4, 8'd2, 1'b0}) begin errors++; $display("FAIL unsigned_stats: got %h %h %0d %b want f 4 2 0", max_a, min_a, lt_cnt, empty); end
  endtask

  task automatic test_saturation();
    logic [1:0] want_cnt;
    pulse_clr();
    for (int i = 0; i < 5; i++) begin
      drive(4'h1, 4'h2, 1'b0, 1'b0);
      want_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
      checks++;
      if ({lt_cnt2, cnt_sat2} !== {want_cnt, i >= 2}) begin errors++; $display("FAIL sat_%0d: got cnt=%0d sat=%b want cnt=%0d sat=%b", i, lt_cnt2, cnt_sat2, want_cnt, i >= 2); end
    end
    checks++;
    if ({lt_cnt, cnt_sat} !== {8'd5, 1'b0}) begin errors++; $display("FAIL wide_cnt: got %0d %b want 5 0", lt_cnt, cnt_sat); end
    pulse_clr();
    checks++;
    if ({lt_cnt2, cnt_sat2, empty2} !== {2'd0, 1'b0, 1'b1}) begin errors++; $display("FAIL sat_clr: got %0d %b %b want 0 0 1", lt_cnt2, cnt_sat2, empty2); end
  endtask

  task automatic test_clr_with_sample();
    drive(4'h2, 4'h1, 1'b0, 1'b0);
    drive(4'h9, 4'h0, 1'b0, 1'b0);
    drive(4'h5, 4'h3, 1'b1, 1'b1);
    checks++;
    if ({max_a, min_a, lt_cnt, empty} !== {4'h5, 4'h5, 8'd0, 1'b0}) begin errors++; $display("FAIL clr_sample: got %h %h %0d %b want 5 5 0 0", max_a, min_a, lt_cnt, empty); end
    drive(4'hF, 4'h0, 1'b0, 1'b0);
    checks++;
    if ({max_a, min_a, lt_cnt} !== {4'h5, 4'hF, 8'd1}) begin errors++; $display("FAIL clr_sample_mode: got %h %h %0d want 5 f 1", max_a, min_a, lt_cnt); end
  endtask

  task automatic test_reset_mid();
    drive(4'h3, 4'h4, 1'b0, 1'b0);
    a = 4'h6;
    b = 4'h7;
    in_valid = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, ans_u, ans_s, eq, max_a, min_a, lt_cnt, cnt_sat, empty} !== {4'b0, 4'h0, 4'h0, 8'h0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL reset_mid: got %b %b %b %b %h %h %h %b %b want 0 0 0 0 0 0 00 0 1", out_valid, ans_u, ans_s, eq, max_a, min_a, lt_cnt, cnt_sat, empty);
    end
    checks++;
    if ({out_valid2, lt_cnt2, empty2} !== {1'b0, 2'd0, 1'b1}) begin errors++; $display("FAIL reset_mid2: got %b %0d %b want 0 0 1", out_valid2, lt_cnt2, empty2); end
    checks++;
    if (sbq.size() != 0) begin errors++; $display("FAIL scoreboard_left: got %0d want 0", sbq.size()); end
  endtask

  initial begin
    test_reset();
    test_compare();
    test_signed_stats();
    test_unsigned_stats();
    test_saturation();
    test_clr_with_sample();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
